// File: rtl/ahb_lite_sram_slave.sv
// AHB-lite slave fronting a word-organised SRAM: programmable wait states,
// sub-word byte lanes, two-cycle ERROR response and write-to-read bypass.
module ahb_lite_sram_slave #(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           MEM_DEPTH   = 1024,
   parameter int unsigned           WAIT_STATES = 0,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
   input  logic                  hclk,
   input  logic                  hreset,
   input  logic                  hsel,
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [2:0]            hburst,
   input  logic [3:0]            hprot,
   input  logic                  hready,
   input  logic [DATA_WIDTH-1:0] hwdata,
   output logic [DATA_WIDTH-1:0] hrdata,
   output logic                  hreadyout,
   output logic [1:0]            hresp
);

   localparam int unsigned BYTES  = DATA_WIDTH / 8;
   localparam int unsigned LANE_W = $clog2(BYTES);
   localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * BYTES);

   if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
      $error("ahb_lite_sram_slave: DATA_WIDTH must be 32 or 64");
   end
   if (WAIT_STATES > 15) begin : g_bad_wait_states
      $error("ahb_lite_sram_slave: WAIT_STATES must be in 0..15");
   end

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

   state_e                  state_q;
   logic [3:0]              cnt_q;
   logic                    wr_q;
   logic [IDX_W-1:0]        idx_q;
   logic [LANE_W-1:0]       lane_q;
   logic [2:0]              size_q;
   logic                    hreadyout_q;
   logic [1:0]              hresp_q;
   logic [DATA_WIDTH-1:0]   hrdata_q;
   logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

   logic [ADDR_WIDTH-1:0]   off_c;
   logic [IDX_W-1:0]        idx_c;
   logic [LANE_W-1:0]       amask_c;
   logic                    err_c;
   logic                    capture_c;
   logic [31:0]             lo_c;
   logic [31:0]             hi_c;
   logic [DATA_WIDTH-1:0]   wmask_c;
   logic [DATA_WIDTH-1:0]   merged_c;
   logic                    commit_c;
   logic [IDX_W-1:0]        rd_idx_c;
   logic [DATA_WIDTH-1:0]   rd_word_c;
   logic                    unused_c;

   assign hrdata    = hrdata_q;
   assign hreadyout = hreadyout_q;
   assign hresp     = hresp_q;
   assign unused_c  = ^{hburst, hprot, htrans[0], off_c};

   // Address-phase decode and legality check
   always_comb begin
      off_c     = haddr - BASE_ADDR;
      idx_c     = off_c[LANE_W +: IDX_W];
      amask_c   = ~({LANE_W{1'b1}} << hsize);
      err_c     = (haddr < BASE_ADDR) || ({1'b0, off_c} >= MEM_BYTES) ||
                  (hsize > 3'(LANE_W)) || (|(haddr[LANE_W-1:0] & amask_c));
      capture_c = (state_q == S_IDLE || state_q == S_DATA || state_q == S_ERR2) &&
                  hsel && hready && htrans[1];
   end

   // Lane merge of the completing write; a read entering DATA on the same
   // edge sees the merged word rather than the stale array contents.
   always_comb begin
      lo_c = 32'(lane_q);
      hi_c = lo_c + (32'd1 << size_q);
      for (int unsigned b = 0; b < BYTES; b++) begin
         wmask_c[8*b +: 8] = (b >= lo_c && b < hi_c) ? 8'hFF : 8'h00;
      end
      merged_c  = (mem[idx_q] & ~wmask_c) | (hwdata & wmask_c);
      commit_c  = (state_q == S_DATA) && wr_q;
      rd_idx_c  = capture_c ? idx_c : idx_q;
      rd_word_c = (commit_c && (idx_q == rd_idx_c)) ? merged_c : mem[rd_idx_c];
   end

   always_ff @(posedge hclk) begin
      if (commit_c) begin
         mem[idx_q] <= merged_c;
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         wr_q        <= 1'b0;
         idx_q       <= '0;
         lane_q      <= '0;
         size_q      <= 3'd0;
         hreadyout_q <= 1'b1;
         hresp_q     <= 2'b00;
         hrdata_q    <= '0;
      end else begin
         case (state_q)
            S_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q     <= S_DATA;
                  hreadyout_q <= 1'b1;
                  if (!wr_q) begin
                     hrdata_q <= rd_word_c;
                  end
               end
            end
            S_ERR1: begin
               state_q     <= S_ERR2;
               hreadyout_q <= 1'b1;
            end
            default: begin
               // IDLE, DATA and ERR2 all accept a new address phase
               if (capture_c) begin
                  wr_q   <= hwrite;
                  idx_q  <= idx_c;
                  lane_q <= off_c[LANE_W-1:0];
                  size_q <= hsize;
                  if (err_c) begin
                     state_q     <= S_ERR1;
                     hreadyout_q <= 1'b0;
                     hresp_q     <= 2'b01;
                     hrdata_q    <= '0;
                  end else if (WAIT_STATES != 0) begin
                     state_q     <= S_WAIT;
                     cnt_q       <= 4'(WAIT_STATES);
                     hreadyout_q <= 1'b0;
                     hresp_q     <= 2'b00;
                  end else begin
                     state_q     <= S_DATA;
                     hreadyout_q <= 1'b1;
                     hresp_q     <= 2'b00;
                     if (!hwrite) begin
                        hrdata_q <= rd_word_c;
                     end
                  end
               end else begin
                  state_q     <= S_IDLE;
                  hreadyout_q <= 1'b1;
                  hresp_q     <= 2'b00;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: two instances (zero and three wait states)
// driven by a pipelined AHB master and checked against a byte-array model.
module tb_ahb_lite_sram_slave;

   localparam int unsigned MEM_DEPTH = 64;
   localparam int unsigned MEM_BYTES = MEM_DEPTH * 4;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [1:0]  trans;
      int          gap;
   } xfer_t;

   logic        hclk = 1'b0;
   logic        hreset;
   logic        dsel;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic [31:0] hwdata;

   logic        hsel0, hsel3;
   logic [31:0] hrdata0, hrdata3, hrdata_m;
   logic        hreadyout0, hreadyout3, rdy_m;
   logic [1:0]  hresp0, hresp3, hresp_m;

   int          n_chk = 0;
   int          n_fail = 0;
   int          dcyc;
   logic [31:0] last_rd;
   logic [7:0]  ref_mem [2][MEM_BYTES];
   xfer_t       xq[$];

   assign hsel0    = hsel & ~dsel;
   assign hsel3    = hsel & dsel;
   assign rdy_m    = dsel ? hreadyout3 : hreadyout0;
   assign hresp_m  = dsel ? hresp3 : hresp0;
   assign hrdata_m = dsel ? hrdata3 : hrdata0;

   always #5 hclk = ~hclk;

   ahb_lite_sram_slave #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(MEM_DEPTH),
      .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)
   ) u_dut0 (
      .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
      .hready(hreadyout0), .hwdata(hwdata), .hrdata(hrdata0),
      .hreadyout(hreadyout0), .hresp(hresp0)
   );

   ahb_lite_sram_slave #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(MEM_DEPTH),
      .WAIT_STATES(3), .BASE_ADDR(32'h0000_1000)
   ) u_dut3 (
      .hclk(hclk), .hreset(hreset), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
      .hready(hreadyout3), .hwdata(hwdata), .hrdata(hrdata3),
      .hreadyout(hreadyout3), .hresp(hresp3)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] base_of(input int d);
      return (d != 0) ? 32'h0000_1000 : 32'h0000_0000;
   endfunction

   function automatic int ws_of(input int d);
      return (d != 0) ? 3 : 0;
   endfunction

   function automatic bit is_err(input int d, input logic [31:0] a, input logic [2:0] s);
      logic [31:0] off;
      if (a < base_of(d)) return 1'b1;
      off = a - base_of(d);
      if (off >= MEM_BYTES) return 1'b1;
      if (s > 3'd2) return 1'b1;
      if ((a % (32'd1 << s)) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_word(input int d, input logic [31:0] a);
      logic [31:0] off;
      off = (a - base_of(d)) & 32'hFFFF_FFFC;
      return {ref_mem[d][off+3], ref_mem[d][off+2], ref_mem[d][off+1], ref_mem[d][off]};
   endfunction

   task automatic ref_write(input int d, input logic [31:0] a, input logic [2:0] s,
                            input logic [31:0] wd);
      logic [31:0] pos;
      for (int k = 0; k < (1 << s); k++) begin
         pos = a - base_of(d) + 32'(k);
         ref_mem[d][pos] = wd[8*pos[1:0] +: 8];
      end
   endtask

   task automatic push(input logic [31:0] a, input logic w, input logic [2:0] s,
                       input logic [31:0] wd, input logic [1:0] t, input int g);
      xfer_t x;
      x.addr = a; x.wr = w; x.size = s; x.wdata = wd; x.trans = t; x.gap = g;
      xq.push_back(x);
   endtask

   // Pipelined master: entered and left at posedge+1; checks each completion
   task automatic run_seq(input int d);
      int    ai, gap, cyc, d_wait;
      bit    a_act, d_act, rdy, e;
      xfer_t a_x, d_x;
      ai = 0; cyc = 0; d_wait = 0; a_act = 0; d_act = 0; dcyc = 0;
      dsel = (d != 0);
      gap = (xq.size() > 0) ? xq[0].gap : 0;
      while ((ai < xq.size() || a_act || d_act) && cyc < 4000) begin
         if (!a_act && ai < xq.size()) begin
            if (gap > 0) gap--;
            else begin
               a_x = xq[ai]; ai++; a_act = 1;
               if (ai < xq.size()) gap = xq[ai].gap;
            end
         end
         if (a_act) begin
            hsel = 1'b1; haddr = a_x.addr; htrans = a_x.trans;
            hwrite = a_x.wr; hsize = a_x.size;
         end else begin
            haddr = $urandom(); hwrite = 1'($urandom()); hsize = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) begin hsel = 1'b0; htrans = 2'($urandom()); end
            else begin hsel = 1'b1; htrans = {1'b0, 1'($urandom())}; end
         end
         hburst = 3'($urandom()); hprot = 4'($urandom());
         hwdata = (d_act && d_x.wr) ? d_x.wdata : $urandom();
         @(negedge hclk);
         rdy = rdy_m;
         if (d_act) begin
            dcyc++;
            e = is_err(d, d_x.addr, d_x.size);
            if (!rdy) begin
               d_wait++;
               check_eq("wait_resp", 32'(hresp_m), e ? 32'd1 : 32'd0);
            end else begin
               check_eq("resp", 32'(hresp_m), e ? 32'd1 : 32'd0);
               check_eq("waits", 32'(d_wait), e ? 32'd1 : 32'(ws_of(d)));
               if (d_x.wr) begin
                  if (!e) ref_write(d, d_x.addr, d_x.size, d_x.wdata);
               end else begin
                  check_eq("rdata", hrdata_m, e ? 32'd0 : ref_word(d, d_x.addr));
                  last_rd = hrdata_m;
               end
               d_act = 0;
            end
         end else begin
            check_eq("idle_out", 32'({rdy, hresp_m}), 32'b100);
         end
         if (a_act && rdy) begin
            d_act = 1; d_x = a_x; d_wait = 0; a_act = 0;
         end
         @(posedge hclk); #1;
         cyc++;
      end
      if (cyc >= 4000) begin
         n_chk++; n_fail++;
         $display("FAIL seq_timeout: observed %0d cycles expected completion", cyc);
      end
      hsel = 1'b0; htrans = 2'b00;
      xq.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] pre, a;
      logic [2:0]  s;
      xfer_t       prev;
      bit          have_prev;

      hreset = 1'b1; dsel = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00;
      hwrite = 1'b0; hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; hwdata = '0;
      last_rd = '0;
      repeat (2) @(posedge hclk);
      #1;
      check_eq("rst_rdy0",  32'(hreadyout0), 32'd1);
      check_eq("rst_resp0", 32'(hresp0), 32'd0);
      check_eq("rst_data0", hrdata0, 32'd0);
      check_eq("rst_rdy3",  32'(hreadyout3), 32'd1);
      check_eq("rst_resp3", 32'(hresp3), 32'd0);
      check_eq("rst_data3", hrdata3, 32'd0);
      hreset = 1'b0;
      @(posedge hclk); #1;

      // Give every word a known value
      for (int d = 0; d < 2; d++) begin
         for (int w = 0; w < MEM_DEPTH; w++)
            push(base_of(d) + 32'(4 * w), 1'b1, 3'd2, $urandom(), 2'b10, 0);
         run_seq(d);
      end

      push(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 2'b10, 0);
      push(32'h10, 1'b0, 3'd2, 32'h0, 2'b10, 0);
      run_seq(0);
      check_eq("deadbeef", last_rd, 32'hDEADBEEF);

      push(32'h20, 1'b1, 3'd2, 32'h11223344, 2'b10, 0);
      push(32'h21, 1'b1, 3'd0, 32'h5555AA55, 2'b10, 0);
      push(32'h22, 1'b1, 3'd1, 32'hBEEF1234, 2'b10, 0);
      push(32'h20, 1'b0, 3'd2, 32'h0, 2'b10, 1);
      run_seq(0);
      check_eq("lanes", last_rd, 32'hBEEFAA44);

      pre = ref_word(0, 32'h0);
      push(32'h100, 1'b0, 3'd2, 32'h0, 2'b10, 0);
      push(32'h02,  1'b1, 3'd2, 32'hCAFEF00D, 2'b10, 0);
      push(32'h00,  1'b1, 3'd3, 32'hCAFEF00D, 2'b10, 0);
      push(32'h00,  1'b0, 3'd2, 32'h0, 2'b10, 0);
      run_seq(0);
      check_eq("err_unchanged", last_rd, pre);

      push(32'h40, 1'b1, 3'd2, 32'h12345678, 2'b10, 0);
      push(32'h40, 1'b0, 3'd2, 32'h0, 2'b10, 0);
      run_seq(0);
      check_eq("bypass", last_rd, 32'h12345678);

      push(32'h1010, 1'b0, 3'd2, 32'h0, 2'b10, 0);
      run_seq(1);
      check_eq("ws3_single_dcyc", 32'(dcyc), 32'd4);
      for (int k = 0; k < 4; k++)
         push(32'h1020 + 32'(4 * k), 1'b1, 3'd2, $urandom(), (k == 0) ? 2'b10 : 2'b11, 0);
      run_seq(1);
      check_eq("incr4_dcyc", 32'(dcyc), 32'd16);

      // Random traffic with frequent write-then-read of the same location
      for (int d = 0; d < 2; d++) begin
         have_prev = 0;
         for (int i = 0; i < 150; i++) begin
            if (have_prev && prev.wr && $urandom_range(0, 2) == 0) begin
               push(prev.addr, 1'b0, prev.size, 32'h0, 2'b10, 0);
            end else begin
               a = base_of(d) + 32'($urandom_range(0, MEM_BYTES + 24)) - ((d != 0) ? 32'd16 : 32'd0);
               s = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
               if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << s) - 32'd1);
               push(a, 1'($urandom()), s, $urandom(), {1'b1, 1'($urandom())},
                    ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0);
            end
            prev = xq[xq.size() - 1];
            have_prev = 1;
         end
         run_seq(d);
      end

      // Reset during the wait states of a write must not commit it
      dsel = 1'b1;
      pre = ref_word(1, 32'h1080);
      hsel = 1'b1; haddr = 32'h1080; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
      @(posedge hclk); #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = ~pre;
      check_eq("rst_in_wait", 32'(hreadyout3), 32'd0);
      #2 hreset = 1'b1;
      #1;
      check_eq("async_rdy", 32'(hreadyout3), 32'd1);
      check_eq("async_resp", 32'(hresp3), 32'd0);
      check_eq("async_data", hrdata3, 32'd0);
      @(posedge hclk); #1;
      hreset = 1'b0;
      @(posedge hclk); #1;
      push(32'h1080, 1'b0, 3'd2, 32'h0, 2'b10, 0);
      run_seq(1);
      check_eq("rst_mem_kept", last_rd, pre);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
